// File: rtl/oled_spi_tx_if.sv
// rtl/oled_spi_tx_if.sv - register-side bus of the PMOD OLED SPI transmitter
interface oled_spi_tx_if;
   logic       data_wstrb;
   logic [8:0] data_wdata;
   logic       ctrl_wstrb;
   logic [3:0] ctrl_wdata;
   logic [7:0] status;

   modport master (output data_wstrb, data_wdata, ctrl_wstrb, ctrl_wdata, input status);
   modport slave  (input data_wstrb, data_wdata, ctrl_wstrb, ctrl_wdata, output status);
endinterface

// File: rtl/oled_spi_tx.sv
// rtl/oled_spi_tx.sv - SPI mode-0 byte transmitter for the PMOD OLED with D/C tag and static panel controls
// OLED_SPI_FIFO_EN selects a FIFO_DEPTH byte queue; otherwise a single holding register is used.
module oled_spi_tx #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   oled_spi_tx_if.slave  bus,
   output logic          oled_cs_n,
   output logic          oled_sck,
   output logic          oled_mosi,
   output logic          oled_dc,
   output logic          oled_res_n,
   output logic          oled_vcc_en,
   output logic          oled_pmod_en
);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_low, w_low_nxt;
   logic [2:0] r_bit, w_bit_nxt;
   logic [7:0] r_shift;
   logic       r_tag;
   logic       w_pop, w_shift, w_cnt_end;
   logic       w_push, w_ovf_set, w_full, w_empty, w_busy;
   logic [8:0] w_head;
   logic [3:0] w_level4;
   logic       r_ovf;
   logic       r_cs_n, r_sck, r_mosi, r_dc;
   logic       r_res_n, r_vcc_en, r_pmod_en;

   // A push against a full queue is dropped even when a pop frees a slot that cycle.
   assign w_push    = bus.data_wstrb && !w_full;
   assign w_ovf_set = bus.data_wstrb && w_full;

`ifdef OLED_SPI_FIFO_EN
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [8:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [LVL_W-1:0] r_level;

   assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty  = (r_level == '0);
   assign w_head   = r_mem[r_rptr];
   assign w_level4 = 4'(r_level);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= bus.data_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end
`else
   // FIFO_DEPTH does not apply here: the queue is one holding register.
   localparam int unsigned QDEPTH = (FIFO_DEPTH >= 1) ? 1 : 1;

   logic [8:0] r_hold;
   logic       r_valid;

   assign w_full   = (r_valid == 1'(QDEPTH));
   assign w_empty  = !r_valid;
   assign w_head   = r_hold;
   assign w_level4 = {3'b000, r_valid};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold  <= '0;
         r_valid <= 1'b0;
      end else if (w_push) begin
         r_hold  <= bus.data_wdata;
         r_valid <= 1'b1;
      end else if (w_pop) begin
         r_valid <= 1'b0;
      end
   end
`endif

   assign w_cnt_end = (r_cnt == CNT_LAST);
   assign w_busy    = (r_state != S_IDLE) || !w_empty;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 8'd1;
      w_low_nxt   = r_low;
      w_bit_nxt   = r_bit;
      w_pop       = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: if (w_cnt_end) begin
            w_cnt_nxt   = '0;
            w_low_nxt   = 1'b0;
            w_bit_nxt   = '0;
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: if (w_cnt_end) begin
            w_cnt_nxt = '0;
            // Shifting at the end of the high half makes mosi move with the falling sck.
            if (!r_low) begin
               w_low_nxt = 1'b1;
               w_shift   = 1'b1;
            end else begin
               w_low_nxt = 1'b0;
               if (r_bit == 3'd7) w_state_nxt = S_HOLD;
               else               w_bit_nxt   = r_bit + 3'd1;
            end
         end
         S_HOLD: if (w_cnt_end) begin
            w_cnt_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SETUP;
            end else begin
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: if (w_cnt_end) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_low   <= 1'b0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tag   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_low   <= w_low_nxt;
         r_bit   <= w_bit_nxt;
         if (w_pop)        {r_tag, r_shift} <= w_head;
         else if (w_shift) r_shift <= {r_shift[6:0], 1'b0};
      end
   end

   // Pins are registered from the FSM, so they trail the state by one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cs_n <= 1'b1;
         r_sck  <= 1'b0;
         r_mosi <= 1'b0;
         r_dc   <= 1'b0;
      end else begin
         r_cs_n <= (r_state == S_IDLE) || (r_state == S_GAP);
         r_sck  <= (r_state == S_SHIFT) && !r_low;
         r_mosi <= r_shift[7];
         r_dc   <= r_tag;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_res_n   <= 1'b1;
         r_vcc_en  <= 1'b0;
         r_pmod_en <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (bus.ctrl_wstrb) begin
            r_res_n   <= bus.ctrl_wdata[0];
            r_vcc_en  <= bus.ctrl_wdata[1];
            r_pmod_en <= bus.ctrl_wdata[2];
         end
         if (w_ovf_set)                              r_ovf <= 1'b1;
         else if (bus.ctrl_wstrb && bus.ctrl_wdata[3]) r_ovf <= 1'b0;
      end
   end

   assign bus.status   = {w_level4, 1'b0, r_ovf, w_full, w_busy};
   assign oled_cs_n    = r_cs_n;
   assign oled_sck     = r_sck;
   assign oled_mosi    = r_mosi;
   assign oled_dc      = r_dc;
   assign oled_res_n   = r_res_n;
   assign oled_vcc_en  = r_vcc_en;
   assign oled_pmod_en = r_pmod_en;
endmodule
